// File: rtl/deal_pkg.sv
// Shared types and constants for the Baccarat deal controller.
// Card codes and rule thresholds used by the FSM and the banker table.
package deal_pkg;

  typedef enum logic [3:0] {
    S_RESET,
    S_P1,
    S_D1,
    S_P2,
    S_D2,
    S_EVAL,
    S_P3,
    S_BANK,
    S_D3,
    S_RESULT,
    S_DONE
  } state_t;

  localparam logic [3:0] CARD_BLANK = 4'd0;
  localparam logic [3:0] CARD_ACE   = 4'd1;
  localparam logic [3:0] CARD_NINE  = 4'd9;
  localparam logic [3:0] CARD_KING  = 4'd13;

  localparam logic [3:0] NATURAL  = 4'd8;
  localparam logic [3:0] DRAW_MAX = 4'd5;

  // Tens and faces count zero; blanks count zero too.
  function automatic logic [3:0] card_value(input logic [3:0] code);
    card_value = (code >= CARD_ACE && code <= CARD_NINE) ? code : 4'd0;
  endfunction

endpackage

// File: rtl/deal_if.sv
// Controller <-> card datapath bundle: scores in, strobes and lights out.
// master is the controller side, slave is the datapath side.
interface deal_if;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3;
  logic       load_pcard1;
  logic       load_pcard2;
  logic       load_pcard3;
  logic       load_dcard1;
  logic       load_dcard2;
  logic       load_dcard3;
  logic       player_win_light;
  logic       dealer_win_light;
  logic       hand_done;

  modport master (
    input  pscore, dscore, pcard3,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output player_win_light, dealer_win_light,
    output hand_done
  );

  modport slave (
    output pscore, dscore, pcard3,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  player_win_light, dealer_win_light,
    input  hand_done
  );
endinterface

// File: rtl/banker_draw_rule.sv
// Banker third-card table: dscore and player third-card value -> draw.
// Purely combinational.
module banker_draw_rule (
  input  logic [3:0] dscore,
  input  logic [3:0] value,
  output logic       draw
);
  always_comb begin
    draw = 1'b0;
    unique case (1'b1)
      (dscore <= 4'd2): draw = 1'b1;
      (dscore == 4'd3): draw = (value != 4'd8);
      (dscore == 4'd4): draw = (value >= 4'd2) && (value <= 4'd7);
      (dscore == 4'd5): draw = (value >= 4'd4) && (value <= 4'd7);
      (dscore == 4'd6): draw = (value >= 4'd6) && (value <= 4'd7);
      default:          draw = 1'b0;
    endcase
  end
endmodule

// File: rtl/deal_controller.sv
// Moore FSM sequencing one Baccarat hand: deal strobes, third-card
// rules and registered win lights.
module deal_controller
  import deal_pkg::*;
(
  input  logic   slow_clock,
  input  logic   resetb,
  deal_if.master dif
);
  state_t state, nxt;
  logic   pl_q, dl_q;
  logic   bank_draw;
  logic   natural;

  banker_draw_rule u_rule (
    .dscore (dif.dscore),
    .value  (card_value(dif.pcard3)),
    .draw   (bank_draw)
  );

  assign natural = (dif.pscore >= NATURAL) || (dif.dscore >= NATURAL);

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state <= S_RESET;
      pl_q  <= 1'b0;
      dl_q  <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        S_RESULT: begin
          pl_q <= dif.pscore >= dif.dscore;
          dl_q <= dif.dscore >= dif.pscore;
        end
        S_DONE: begin
          pl_q <= pl_q;
          dl_q <= dl_q;
        end
        default: begin
          pl_q <= 1'b0;
          dl_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    nxt = S_RESET;
    case (state)
      S_RESET:  nxt = S_P1;
      S_P1:     nxt = S_D1;
      S_D1:     nxt = S_P2;
      S_P2:     nxt = S_D2;
      S_D2:     nxt = S_EVAL;
      S_EVAL: begin
        if (natural)                   nxt = S_RESULT;
        else if (dif.pscore <= DRAW_MAX) nxt = S_P3;
        else if (dif.dscore <= DRAW_MAX) nxt = S_D3;
        else                           nxt = S_RESULT;
      end
      S_P3:     nxt = S_BANK;
      S_BANK:   nxt = bank_draw ? S_D3 : S_RESULT;
      S_D3:     nxt = S_RESULT;
      S_RESULT: nxt = S_DONE;
      S_DONE:   nxt = S_DONE;
      default:  nxt = S_RESET;
    endcase
  end

  always_comb begin
    dif.load_pcard1 = 1'b0;
    dif.load_pcard2 = 1'b0;
    dif.load_pcard3 = 1'b0;
    dif.load_dcard1 = 1'b0;
    dif.load_dcard2 = 1'b0;
    dif.load_dcard3 = 1'b0;
    dif.hand_done   = 1'b0;
    case (state)
      S_P1:    dif.load_pcard1 = 1'b1;
      S_D1:    dif.load_dcard1 = 1'b1;
      S_P2:    dif.load_pcard2 = 1'b1;
      S_D2:    dif.load_dcard2 = 1'b1;
      S_P3:    dif.load_pcard3 = 1'b1;
      S_D3:    dif.load_dcard3 = 1'b1;
      S_DONE:  dif.hand_done   = 1'b1;
      default: ;
    endcase
  end

  assign dif.player_win_light = pl_q;
  assign dif.dealer_win_light = dl_q;
endmodule

// File: tb/tb_deal_controller.sv
// Directed bench for deal_controller: hand table, async reset
// sequence and an exhaustive banker-rule sweep.
module tb_deal_controller;

  logic slow_clock = 1'b0;
  logic resetb     = 1'b0;
  deal_if dif ();

  deal_controller dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .dif        (dif)
  );

  logic [3:0] bd, bv;
  logic       bdraw;

  banker_draw_rule u_rule (
    .dscore (bd),
    .value  (bv),
    .draw   (bdraw)
  );

  always #5 slow_clock = ~slow_clock;

  logic [5:0] loads;
  assign loads = {dif.load_dcard3, dif.load_dcard2, dif.load_dcard1,
                  dif.load_pcard3, dif.load_pcard2, dif.load_pcard1};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] ep, ed, c3, fp, fd;
    bit p3, d3;
    int edges;
    bit pw, dw;
  } vec_t;

  vec_t tbl [10];

  function automatic bit model_draw(input int d, input int code);
    int v;
    v = (code >= 1 && code <= 9) ? code : 0;
    if (d <= 2) return 1'b1;
    if (d == 3) return v != 8;
    if (d == 4) return v >= 2 && v <= 7;
    if (d == 5) return v >= 4 && v <= 7;
    if (d == 6) return v == 6 || v == 7;
    return 1'b0;
  endfunction

  task automatic run_hand(input int idx, input vec_t v);
    logic [5:0] exp_order [4];
    bit   order_ok, onehot_ok, dark_ok, p3s, d3s;
    int   edges;
    exp_order[0] = 6'b000001;
    exp_order[1] = 6'b001000;
    exp_order[2] = 6'b000010;
    exp_order[3] = 6'b010000;
    order_ok = 1; onehot_ok = 1; dark_ok = 1;
    p3s = 0; d3s = 0; edges = 0;
    resetb = 1'b0;
    #1;
    chk($sformatf("h%0d reset_outs", idx),
        {loads, dif.player_win_light, dif.dealer_win_light,
         dif.hand_done}, 0);
    @(negedge slow_clock);
    dif.pscore = v.ep;
    dif.dscore = v.ed;
    dif.pcard3 = 4'd0;
    resetb = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge slow_clock);
      @(negedge slow_clock);
      if (dif.hand_done) begin
        edges = n;
        break;
      end
      if (n <= 4 && loads != exp_order[n-1]) order_ok = 0;
      if ($countones(loads) > 1) onehot_ok = 0;
      if (dif.player_win_light || dif.dealer_win_light) dark_ok = 0;
      if (dif.load_pcard3) begin
        p3s = 1;
        dif.pcard3 = v.c3;
        dif.pscore = v.fp;
      end
      if (dif.load_dcard3) begin
        d3s = 1;
        dif.dscore = v.fd;
      end
    end
    chk($sformatf("h%0d deal_order", idx), order_ok, 1);
    chk($sformatf("h%0d onehot", idx), onehot_ok, 1);
    chk($sformatf("h%0d lights_dark", idx), dark_ok, 1);
    chk($sformatf("h%0d pcard3_load", idx), p3s, v.p3);
    chk($sformatf("h%0d dcard3_load", idx), d3s, v.d3);
    chk($sformatf("h%0d edges", idx), edges, v.edges);
    chk($sformatf("h%0d player_light", idx), dif.player_win_light, v.pw);
    chk($sformatf("h%0d dealer_light", idx), dif.dealer_win_light, v.dw);
    repeat (3) @(negedge slow_clock);
    chk($sformatf("h%0d hold", idx),
        {dif.hand_done, dif.player_win_light, dif.dealer_win_light, loads},
        {1'b1, v.pw, v.dw, 6'b0});
  endtask

  initial begin
    dif.pscore = 4'd0;
    dif.dscore = 4'd0;
    dif.pcard3 = 4'd0;
    bd = 4'd0;
    bv = 4'd0;

    tbl[0] = '{4'd8, 4'd3, 4'd0,  4'd8, 4'd3, 0, 0, 7,  1, 0};
    tbl[1] = '{4'd4, 4'd5, 4'd6,  4'd2, 4'd9, 1, 1, 10, 0, 1};
    tbl[2] = '{4'd3, 4'd4, 4'd12, 4'd3, 4'd4, 1, 0, 9,  0, 1};
    tbl[3] = '{4'd7, 4'd5, 4'd0,  4'd7, 4'd7, 0, 1, 8,  1, 1};
    tbl[4] = '{4'd6, 4'd6, 4'd0,  4'd6, 4'd6, 0, 0, 7,  1, 1};
    tbl[5] = '{4'd2, 4'd9, 4'd0,  4'd2, 4'd9, 0, 0, 7,  0, 1};
    tbl[6] = '{4'd5, 4'd3, 4'd8,  4'd3, 4'd3, 1, 0, 9,  1, 1};
    tbl[7] = '{4'd0, 4'd7, 4'd1,  4'd1, 4'd7, 1, 0, 9,  0, 1};
    tbl[8] = '{4'd1, 4'd0, 4'd13, 4'd1, 4'd5, 1, 1, 10, 0, 1};
    tbl[9] = '{4'd7, 4'd6, 4'd0,  4'd7, 4'd6, 0, 0, 7,  1, 0};

    for (int i = 0; i < 10; i++) run_hand(i, tbl[i]);

    // Reset dropped in the middle of S_P2.
    resetb = 1'b0;
    @(negedge slow_clock);
    dif.pscore = 4'd1;
    dif.dscore = 4'd1;
    dif.pcard3 = 4'd0;
    resetb = 1'b1;
    repeat (3) @(posedge slow_clock);
    @(negedge slow_clock);
    chk("mid_p2_strobe", loads, 6'b000010);
    #2 resetb = 1'b0;
    #1;
    chk("async_loads", loads, 0);
    chk("async_lights",
        {dif.player_win_light, dif.dealer_win_light, dif.hand_done}, 0);
    @(negedge slow_clock);
    resetb = 1'b1;
    @(posedge slow_clock);
    @(negedge slow_clock);
    chk("restart_p1", loads, 6'b000001);

    for (int d = 0; d <= 7; d++) begin
      for (int c = 1; c <= 13; c++) begin
        bd = 4'(d);
        bv = (c <= 9) ? 4'(c) : 4'd0;
        #1;
        chk($sformatf("rule d%0d c%0d", d, c), bdraw, model_draw(d, c));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
